// File: rtl/blk_45f30e.sv
// Eight-lane write-side demux register with a valid/ready frame handoff.
//
// Each cycle in FILL, one BITS-wide DATA word is written into the lane that
// SELECT addresses. Once all eight lanes have been written, the block moves
// to HOLD and presents the whole frame on OUT with OUT_VALID high. It stays
// in HOLD until the consumer takes the frame with OUT_READY.
//
// Ports:
//   CLK          - clock, rising edge
//   RESET        - synchronous, active-high reset
//   DATA         - write data word (BITS)
//   SELECT       - destination lane index 0..7
//   WRITE_ENABLE - write request for DATA into lane SELECT
//   IN_READY     - writes are accepted this cycle (FILL state)
//   OUT          - packed lane registers, OUT[i] is lane i
//   VALID_MASK   - bit i set once lane i is written in the current frame
//   OVERWRITE    - sticky: some lane was written twice in the current frame
//   OUT_VALID    - full frame available on OUT (HOLD state)
//   OUT_READY    - consumer accepts the frame
module blk_45f30e #(
    parameter int unsigned BITS = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [BITS-1:0]       DATA,
    input  logic [2:0]            SELECT,
    input  logic                  WRITE_ENABLE,
    output logic                  IN_READY,
    output logic [7:0][BITS-1:0]  OUT,
    output logic [7:0]            VALID_MASK,
    output logic                  OVERWRITE,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e                 state_q, state_d;
    logic [7:0][BITS-1:0]   lane_q, lane_d;
    logic [7:0]             mask_q, mask_d;
    logic                   ovw_q, ovw_d;

    logic                   wr_acc;
    logic [7:0]             sel_onehot;
    logic [7:0]             lane_we;

    // Writes are only accepted while the registered state says FILL.
    assign wr_acc     = WRITE_ENABLE && (state_q == StFill);
    assign sel_onehot = 8'b0000_0001 << SELECT;
    assign lane_we    = wr_acc ? sel_onehot : 8'h00;

    // Per-lane enable registers driven by the gated one-hot decoder.
    always_comb begin
        lane_d = lane_q;
        for (int i = 0; i < 8; i++) begin
            if (lane_we[i]) begin
                lane_d[i] = DATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ovw_d   = ovw_q;
        unique case (state_q)
            StFill: begin
                if (wr_acc) begin
                    mask_d = mask_q | sel_onehot;
                    if ((mask_q & sel_onehot) != 8'h00) begin
                        ovw_d = 1'b1;
                    end
                    if ((mask_q | sel_onehot) == 8'hFF) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                // Lane data is deliberately kept; only the frame bookkeeping clears.
                if (OUT_READY) begin
                    mask_d  = 8'h00;
                    ovw_d   = 1'b0;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StFill;
            lane_q  <= '0;
            mask_q  <= 8'h00;
            ovw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            mask_q  <= mask_d;
            ovw_q   <= ovw_d;
        end
    end

    // Handshake outputs decode from registered state only.
    assign IN_READY   = (state_q == StFill);
    assign OUT_VALID  = (state_q == StHold);
    assign OUT        = lane_q;
    assign VALID_MASK = mask_q;
    assign OVERWRITE  = ovw_q;

endmodule

// File: tb/tb_blk_45f30e.sv
// Directed testbench for blk_45f30e: reset, in-order fill, HOLD write drop,
// handshake with stale-lane retention, overwrite flag, reset mid-frame.
module tb_blk_45f30e;

    localparam int unsigned BITS = 32;

    logic                  CLK;
    logic                  RESET;
    logic [BITS-1:0]       DATA;
    logic [2:0]            SELECT;
    logic                  WRITE_ENABLE;
    logic                  IN_READY;
    logic [7:0][BITS-1:0]  OUT;
    logic [7:0]            VALID_MASK;
    logic                  OVERWRITE;
    logic                  OUT_VALID;
    logic                  OUT_READY;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [7:0][BITS-1:0]  exp_out;

    blk_45f30e #(
        .BITS(BITS)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DATA        (DATA),
        .SELECT      (SELECT),
        .WRITE_ENABLE(WRITE_ENABLE),
        .IN_READY    (IN_READY),
        .OUT         (OUT),
        .VALID_MASK  (VALID_MASK),
        .OVERWRITE   (OVERWRITE),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [BITS-1:0] d);
        WRITE_ENABLE = 1'b1;
        SELECT       = sel;
        DATA         = d;
        tick();
        WRITE_ENABLE = 1'b0;
    endtask

    initial begin
        RESET        = 1'b0;
        DATA         = '0;
        SELECT       = 3'd0;
        WRITE_ENABLE = 1'b0;
        OUT_READY    = 1'b0;
        #2;

        // 1. Reset wins over a concurrent write.
        RESET        = 1'b1;
        WRITE_ENABLE = 1'b1;
        SELECT       = 3'd5;
        DATA         = 32'hDEADBEEF;
        tick();
        tick();
        RESET        = 1'b0;
        WRITE_ENABLE = 1'b0;
        check("rst_out", OUT, 256'h0);
        check("rst_mask", VALID_MASK, 8'h00);
        check("rst_ovalid", OUT_VALID, 1'b0);
        check("rst_inready", IN_READY, 1'b1);
        check("rst_ovw", OVERWRITE, 1'b0);

        // 2. In-order fill.
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 32'h1000_0000 + i);
            check("fill_mask", VALID_MASK, 8'((9'h002 << i) - 9'h001));
            check("fill_ovalid", OUT_VALID, (i == 7) ? 1'b1 : 1'b0);
        end
        check("fill_lane3", OUT[3], 32'h1000_0003);
        check("fill_inready", IN_READY, 1'b0);
        check("fill_ovw", OVERWRITE, 1'b0);

        // 3. Write in HOLD is dropped.
        wr(3'd2, 32'hFFFF_FFFF);
        check("hold_lane2", OUT[2], 32'h1000_0002);
        check("hold_mask", VALID_MASK, 8'hFF);
        check("hold_ovalid", OUT_VALID, 1'b1);

        // 4. Handshake; simultaneous write is dropped; lanes are retained.
        OUT_READY = 1'b1;
        wr(3'd0, 32'h0000_0055);
        OUT_READY = 1'b0;
        check("hs_ovalid", OUT_VALID, 1'b0);
        check("hs_inready", IN_READY, 1'b1);
        check("hs_mask", VALID_MASK, 8'h00);
        check("hs_lane7", OUT[7], 32'h1000_0007);
        check("hs_lane0", OUT[0], 32'h1000_0000);
        tick();
        check("hs_mask_idle", VALID_MASK, 8'h00);

        // 5. Out-of-order fill with overwrite.
        wr(3'd7, 32'hA);
        check("ow_first", OVERWRITE, 1'b0);
        wr(3'd0, 32'hB);
        wr(3'd7, 32'hC);
        check("ow_set", OVERWRITE, 1'b1);
        check("ow_mask", VALID_MASK, 8'h81);
        for (int i = 1; i < 7; i++) begin
            wr(3'(i), 32'h20 + i);
            check("ow_ovalid", OUT_VALID, (i == 6) ? 1'b1 : 1'b0);
        end
        check("ow_lane7", OUT[7], 32'hC);
        check("ow_lane0", OUT[0], 32'hB);
        check("ow_sticky", OVERWRITE, 1'b1);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("ow_clear", OVERWRITE, 1'b0);
        check("ow_consumed", OUT_VALID, 1'b0);

        // 6. Reset mid-frame, then refill with OUT_READY held high.
        for (int i = 0; i < 4; i++) wr(3'(i), 32'h30 + i);
        check("mid_mask", VALID_MASK, 8'h0F);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_rst_mask", VALID_MASK, 8'h00);
        check("mid_rst_out", OUT, 256'h0);
        check("mid_rst_inready", IN_READY, 1'b1);
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_out[i] = 32'h40 + i;
            wr(3'(7 - i), 32'h40 + 7 - i);
        end
        check("refill_ovalid", OUT_VALID, 1'b1);
        check("refill_mask", VALID_MASK, 8'hFF);
        check("refill_out", OUT, exp_out);
        tick();
        check("refill_consumed", OUT_VALID, 1'b0);
        check("refill_inready", IN_READY, 1'b1);
        OUT_READY = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
